game_timer: RTL and testbench
=============================

# game_timer

Parametrised tick timer for the game logic: divides the board clock down to a configurable game tick and maintains an up/down count with preset load, pause, synchronous clear, lap capture and terminal detection. It is the next generation of the 0.1 s game counter. It sits between the board clock/keys/switches and the score/display logic, which consume `counter_out`, `lap_out` and the one-cycle `tick`/`done` strobes.

## Interface
- `CLK_HZ`, 10_000_000, input clock frequency in Hz.
- `TICK_HZ`, 10, count rate in Hz; `DIV = CLK_HZ / TICK_HZ`, must be ≥ 2.
- `WIDTH`, 10, count width in bits.
- `MAX_COUNT`, 999, terminal value for up-counting and reload value for down-wrap; must be ≤ 2^WIDTH−1.
- `WRAP`, 1, 1 = wrap at terminal, 0 = saturate and set `expired`.

Ports:
- `CLOCK10M`  in  1  system clock.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `CLEAR`  in  1  synchronous clear of count, prescaler and `expired`.
- `LOAD`  in  1  synchronous load of `LOAD_VALUE`.
- `LOAD_VALUE`  in  WIDTH  preset value; clamped to `MAX_COUNT`.
- `RUN`  in  1  level: counting enabled (0 = pause).
- `DOWN`  in  1  level: 1 = count down, 0 = count up.
- `LAP`  in  1  strobe: capture the current count into `lap_out`.
- `counter_out`  out  WIDTH  current count.
- `lap_out`  out  WIDTH  last captured count.
- `tick`  out  1  one-cycle pulse on every count update.
- `done`  out  1  one-cycle pulse when the count reaches the terminal value.
- `expired`  out  1  sticky flag; only set when `WRAP=0`.

## Operation
- The prescaler `pre` counts 0..DIV−1 (width `$clog2(DIV)`).
  - It advances only when `RUN=1` and `expired=0`, and holds its value while paused, so a resumed period continues mid-way.
  - A tick event occurs when `pre==DIV−1` and it is advancing; `pre` then returns to 0.
- The terminal value is `MAX_COUNT` when `DOWN=0` and 0 when `DOWN=1`.
- On a tick event:
  - **Count not at terminal:** count ±1 and `tick=1`. If the new value equals the terminal, `done=1`; if also `WRAP=0`, `expired<=1`.
  - **Count already at terminal, `WRAP=1`:** up wraps to 0, down wraps to `MAX_COUNT`. `tick=1`, `done=0`.
  - **Count already at terminal, `WRAP=0`:** count holds, `expired<=1`, `tick=0`, `done=0`.
- While `expired=1`, the prescaler is frozen and no ticks occur.
  - `expired` is cleared only by `CLEAR`, `LOAD` or reset.
  - A change of `DOWN` does not clear it.
- Priority, highest first: `CLEAR` > `LOAD` > tick event.
  - `CLEAR`: count ← 0, `pre` ← 0, `expired` ← 0; suppresses `tick`/`done`.
  - `LOAD`: count ← min(`LOAD_VALUE`, `MAX_COUNT`), `pre` ← 0, `expired` ← 0; suppresses `tick`/`done`.
- `LAP` high on a cycle: `lap_out` ← `counter_out` as registered before that edge (the pre-update value if a tick coincides).
  - `LAP` is sampled every cycle it is high; it has no priority interaction with `CLEAR` or `LOAD`.
- `DOWN` may change at any time and takes effect on the next tick event.

## Timing
- Reset (`RESET_N=0`, asynchronous assert, synchronous deassert at the board level) forces:
  - `counter_out=0`, `lap_out=0`, `tick=0`, `done=0`, `expired=0`, `pre=0`.
- All outputs are registered; `tick` and `done` are high for exactly one `CLOCK10M` cycle, in the same cycle `counter_out` shows the new value.
- With `pre=0` and `RUN` rising, the first update is visible DIV cycles after the first edge sampling `RUN=1`; later updates follow every DIV running cycles.
- `CLEAR`/`LOAD` take effect on the sampling edge; the next tick comes DIV running cycles later.
- If `RUN` drops on the edge where `pre==DIV−1`, there is no tick and `pre` holds at DIV−1; the tick occurs on the first running edge after resume.
- If reset asserts mid-period, the partial period is discarded.

## Test plan
- **Basic count:** DIV=10, WIDTH=4, MAX_COUNT=9, WRAP=1; reset, `RUN=1`.
  - `counter_out` reaches 1 after exactly 10 cycles, with `tick` pulsing one cycle every 10 cycles.
  - At the 9th update `done` pulses; the 10th update wraps to 0 with no `done`.
- **Pause/resume:** `RUN=0` for 37 cycles after 6 running cycles in a period, then `RUN=1`.
  - The next update occurs 4 running cycles after resume; the count is unchanged during the pause.
- **Countdown saturate:** WRAP=0, `LOAD` with `LOAD_VALUE=3`, `DOWN=1`, `RUN=1`.
  - Count goes 3→2→1→0, with `done` and `expired` on reaching 0.
  - No further `tick`; `counter_out` stays 0 for more than 50 cycles; `LOAD` 5 clears `expired` and counting resumes.
- **Load clamp and priority:** `LOAD_VALUE=15` with MAX_COUNT=9 gives count 9.
  - `CLEAR` and `LOAD` asserted together give count 0.
  - `LOAD` on a tick edge gives the load value with no `tick`.
- **Lap capture:** `LAP` pulsed on the same edge as a tick taking the count 4→5.
  - `lap_out`=4 and `counter_out`=5; `lap_out` holds through later ticks.
- **Async reset:** assert `RESET_N=0` mid-period with count 7 and `expired` set.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release, the first tick comes DIV cycles after `RUN=1` is sampled.

Source files
------------

// File: rtl/game_timer.sv
// Game tick timer: divides the board clock to a game tick and keeps an up/down
// count with preset load, pause, clear, lap capture and terminal detection.
module game_timer #(
  parameter int CLK_HZ    = 10_000_000,
  parameter int TICK_HZ   = 10,
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 999,
  parameter int WRAP      = 1
) (
  input  logic             CLOCK10M,
  input  logic             RESET_N,
  input  logic             CLEAR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             RUN,
  input  logic             DOWN,
  input  logic             LAP,
  output logic [WIDTH-1:0] counter_out,
  output logic [WIDTH-1:0] lap_out,
  output logic             tick,
  output logic             done,
  output logic             expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);

  logic [PW-1:0]    pre;
  logic             advance;
  logic             tick_ev;
  logic [WIDTH-1:0] terminal;
  logic             at_term;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] wrapped;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    advance      = RUN && !expired;
    tick_ev      = advance && (pre == PRE_LAST);
    terminal     = DOWN ? '0 : MAX_V;
    at_term      = (counter_out == terminal);
    stepped      = DOWN ? (counter_out - WIDTH'(1)) : (counter_out + WIDTH'(1));
    wrapped      = DOWN ? MAX_V : '0;
    load_clamped = (LOAD_VALUE > MAX_V) ? MAX_V : LOAD_VALUE;
  end

  always_ff @(posedge CLOCK10M or negedge RESET_N) begin
    if (!RESET_N) begin
      pre         <= '0;
      counter_out <= '0;
      lap_out     <= '0;
      tick        <= 1'b0;
      done        <= 1'b0;
      expired     <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;

      // Lap sees the count registered before this edge, independent of clear/load.
      if (LAP)
        lap_out <= counter_out;

      if (CLEAR) begin
        counter_out <= '0;
        pre         <= '0;
        expired     <= 1'b0;
      end else if (LOAD) begin
        counter_out <= load_clamped;
        pre         <= '0;
        expired     <= 1'b0;
      end else if (tick_ev) begin
        pre <= '0;
        if (!at_term) begin
          counter_out <= stepped;
          tick        <= 1'b1;
          if (stepped == terminal) begin
            done <= 1'b1;
            if (WRAP == 0)
              expired <= 1'b1;
          end
        end else if (WRAP != 0) begin
          counter_out <= wrapped;
          tick        <= 1'b1;
        end else begin
          expired <= 1'b1;
        end
      end else if (advance) begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: DIV=10, WIDTH=4, MAX_COUNT=9, one wrapping and
// one saturating instance driven by the same inputs.
module tb_game_timer;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       run;
  logic       down;
  logic       lap;

  logic [3:0] cnt_w, lap_w, cnt_s, lap_s;
  logic       tick_w, done_w, exp_w, tick_s, done_s, exp_s;

  int tests;
  int fails;

  game_timer #(.CLK_HZ(100), .TICK_HZ(10), .WIDTH(4), .MAX_COUNT(9), .WRAP(1)) dut_w (
    .CLOCK10M(clk), .RESET_N(rst_n), .CLEAR(clear), .LOAD(load),
    .LOAD_VALUE(load_value), .RUN(run), .DOWN(down), .LAP(lap),
    .counter_out(cnt_w), .lap_out(lap_w), .tick(tick_w), .done(done_w),
    .expired(exp_w)
  );

  game_timer #(.CLK_HZ(100), .TICK_HZ(10), .WIDTH(4), .MAX_COUNT(9), .WRAP(0)) dut_s (
    .CLOCK10M(clk), .RESET_N(rst_n), .CLEAR(clear), .LOAD(load),
    .LOAD_VALUE(load_value), .RUN(run), .DOWN(down), .LAP(lap),
    .counter_out(cnt_s), .lap_out(lap_s), .tick(tick_s), .done(done_s),
    .expired(exp_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    run = 1'b0; down = 1'b0; lap = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
    run = 1'b0; down = 1'b0; lap = 1'b0;
    #1;
    tests++;
    if ({cnt_w, lap_w, tick_w, done_w, exp_w} !== 11'd0) begin
      fails++; $display("FAIL reset_wrap: got %b expected 0", {cnt_w, lap_w, tick_w, done_w, exp_w});
    end
    tests++;
    if ({cnt_s, lap_s, tick_s, done_s, exp_s} !== 11'd0) begin
      fails++; $display("FAIL reset_sat: got %b expected 0", {cnt_s, lap_s, tick_s, done_s, exp_s});
    end
  endtask

  task automatic test_basic_count();
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      for (int c = 1; c <= 9; c++) begin
        step();
        tests++;
        if (tick_w !== 1'b0 || cnt_w !== 4'((k - 1) % 10)) begin
          fails++; $display("FAIL basic_idle k=%0d c=%0d: got tick=%b cnt=%0d expected tick=0 cnt=%0d",
                            k, c, tick_w, cnt_w, (k - 1) % 10);
        end
      end
      step();
      tests++;
      if (cnt_w !== 4'(k % 10) || tick_w !== 1'b1 || done_w !== (k == 9)) begin
        fails++; $display("FAIL basic_update k=%0d: got cnt=%0d tick=%b done=%b expected cnt=%0d tick=1 done=%b",
                          k, cnt_w, tick_w, done_w, k % 10, (k == 9));
      end
    end
    step();
    tests++;
    if (tick_w !== 1'b0 || done_w !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_width: got tick=%b done=%b expected 0 0", tick_w, done_w);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 6; c++) step();
    run = 1'b0;
    for (int c = 0; c < 37; c++) begin
      step();
      tests++;
      if (cnt_w !== 4'd0 || tick_w !== 1'b0) begin
        fails++; $display("FAIL pause_hold c=%0d: got cnt=%0d tick=%b expected 0 0", c, cnt_w, tick_w);
      end
    end
    run = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (tick_w !== 1'b0) begin
        fails++; $display("FAIL resume_early c=%0d: got tick=%b expected 0", c, tick_w);
      end
    end
    step();
    tests++;
    if (cnt_w !== 4'd1 || tick_w !== 1'b1) begin
      fails++; $display("FAIL resume_tick: got cnt=%0d tick=%b expected 1 1", cnt_w, tick_w);
    end
  endtask

  task automatic test_countdown_saturate();
    do_reset();
    down = 1'b1; load_value = 4'd3; load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (cnt_s !== 4'd3 || exp_s !== 1'b0) begin
      fails++; $display("FAIL sat_load: got cnt=%0d exp=%b expected 3 0", cnt_s, exp_s);
    end
    run = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < 9; c++) step();
      step();
      tests++;
      if (cnt_s !== 4'(3 - k) || tick_s !== 1'b1 || done_s !== (k == 3) || exp_s !== (k == 3)) begin
        fails++; $display("FAIL sat_down k=%0d: got cnt=%0d tick=%b done=%b exp=%b expected cnt=%0d tick=1 done=%b exp=%b",
                          k, cnt_s, tick_s, done_s, exp_s, 3 - k, (k == 3), (k == 3));
      end
    end
    for (int c = 0; c < 60; c++) begin
      step();
      tests++;
      if (cnt_s !== 4'd0 || tick_s !== 1'b0 || done_s !== 1'b0 || exp_s !== 1'b1) begin
        fails++; $display("FAIL sat_hold c=%0d: got cnt=%0d tick=%b done=%b exp=%b expected 0 0 0 1",
                          c, cnt_s, tick_s, done_s, exp_s);
      end
    end
    load_value = 4'd5; load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (cnt_s !== 4'd5 || exp_s !== 1'b0 || tick_s !== 1'b0) begin
      fails++; $display("FAIL sat_reload: got cnt=%0d exp=%b tick=%b expected 5 0 0", cnt_s, exp_s, tick_s);
    end
    for (int c = 0; c < 10; c++) step();
    tests++;
    if (cnt_s !== 4'd4 || tick_s !== 1'b1) begin
      fails++; $display("FAIL sat_resume: got cnt=%0d tick=%b expected 4 1", cnt_s, tick_s);
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    load_value = 4'd15; load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (cnt_w !== 4'd9) begin
      fails++; $display("FAIL load_clamp: got %0d expected 9", cnt_w);
    end
    clear = 1'b1; load = 1'b1; load_value = 4'd6;
    step();
    clear = 1'b0; load = 1'b0;
    tests++;
    if (cnt_w !== 4'd0) begin
      fails++; $display("FAIL clear_over_load: got %0d expected 0", cnt_w);
    end
    run = 1'b1;
    for (int c = 0; c < 9; c++) step();
    load = 1'b1; load_value = 4'd6;
    step();
    load = 1'b0;
    tests++;
    if (cnt_w !== 4'd6 || tick_w !== 1'b0 || done_w !== 1'b0) begin
      fails++; $display("FAIL load_on_tick: got cnt=%0d tick=%b done=%b expected 6 0 0", cnt_w, tick_w, done_w);
    end
    for (int c = 0; c < 9; c++) step();
    tests++;
    if (cnt_w !== 4'd6 || tick_w !== 1'b0) begin
      fails++; $display("FAIL load_period_early: got cnt=%0d tick=%b expected 6 0", cnt_w, tick_w);
    end
    step();
    tests++;
    if (cnt_w !== 4'd7 || tick_w !== 1'b1) begin
      fails++; $display("FAIL load_period_tick: got cnt=%0d tick=%b expected 7 1", cnt_w, tick_w);
    end
  endtask

  task automatic test_lap();
    do_reset();
    run = 1'b1;
    for (int c = 0; c < 49; c++) step();
    lap = 1'b1;
    step();
    lap = 1'b0;
    tests++;
    if (lap_w !== 4'd4 || cnt_w !== 4'd5 || tick_w !== 1'b1) begin
      fails++; $display("FAIL lap_capture: got lap=%0d cnt=%0d tick=%b expected 4 5 1", lap_w, cnt_w, tick_w);
    end
    for (int c = 0; c < 20; c++) step();
    tests++;
    if (lap_w !== 4'd4 || cnt_w !== 4'd7) begin
      fails++; $display("FAIL lap_hold: got lap=%0d cnt=%0d expected 4 7", lap_w, cnt_w);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    down = 1'b1; run = 1'b1;
    for (int c = 0; c < 30; c++) step();
    for (int c = 0; c < 4; c++) step();
    lap = 1'b1;
    step();
    lap = 1'b0;
    tests++;
    if (cnt_w !== 4'd7 || lap_w !== 4'd7 || exp_s !== 1'b1 || cnt_s !== 4'd0) begin
      fails++; $display("FAIL areset_setup: got cnt_w=%0d lap_w=%0d exp_s=%b cnt_s=%0d expected 7 7 1 0",
                        cnt_w, lap_w, exp_s, cnt_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cnt_w, lap_w, tick_w, done_w, exp_w} !== 11'd0 || {cnt_s, lap_s, tick_s, done_s, exp_s} !== 11'd0) begin
      fails++; $display("FAIL areset_immediate: got w=%b s=%b expected 0 0",
                        {cnt_w, lap_w, tick_w, done_w, exp_w}, {cnt_s, lap_s, tick_s, done_s, exp_s});
    end
    down = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) step();
    tests++;
    if (cnt_w !== 4'd0 || tick_w !== 1'b0) begin
      fails++; $display("FAIL areset_early: got cnt=%0d tick=%b expected 0 0", cnt_w, tick_w);
    end
    step();
    tests++;
    if (cnt_w !== 4'd1 || tick_w !== 1'b1 || cnt_s !== 4'd1) begin
      fails++; $display("FAIL areset_first_tick: got cnt_w=%0d tick=%b cnt_s=%0d expected 1 1 1",
                        cnt_w, tick_w, cnt_s);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic_count();
    test_pause_resume();
    test_countdown_saturate();
    test_load_priority();
    test_lap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
